sdbp_reader: RTL and testbench
==============================

SDBP_READER -- requirements
Module: sdbp_reader

Interface
REQ-001 SHALL have parameter N_LED, default 360, number of 16-bit brightness words per frame (1..1024).
REQ-002 SHALL have parameter CLK_DIV, default 2, clk cycles per sclk half-period (>=1).
REQ-003 SHALL have parameter START_DLY, default 400, clk cycles from sdbpflag rising edge to first RAM fetch (>=1; covers the writer's address window 0..364).
REQ-004 SHALL have parameter LAT_W, default 4, clk cycles le is held high.
REQ-005 clk  input  1  system clock, 25 MHz, all logic on rising edge.
REQ-006 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-007 sdbpflag  input  1  frame-start flag from the frame RAM writer; only its rising edge is used.
REQ-008 rdaddr  output  10  frame RAM read address, registered.
REQ-009 rddata  input  16  frame RAM read data; valid 1 clk after rdaddr changes.
REQ-010 sdo  output  1  serial data to LED driver chain, MSB first.
REQ-011 sclk  output  1  serial clock; driver samples sdo on sclk rising edge.
REQ-012 le  output  1  latch enable, high for LAT_W cycles after the last bit.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 frame_done  output  1  single-cycle pulse when a frame completes.
REQ-015 frame_overrun  output  1  single-cycle pulse when a start edge arrives while busy.

Function
REQ-016 Edge detect: registered copy of sdbpflag (reset value 1); rising edge = sdbpflag & ~copy, so a flag already high at reset release does not start a frame.
REQ-017 States: IDLE, START_WAIT, FETCH, WAIT, LOAD, SHIFT, LATCH, DONE; all outputs registered.
REQ-018 IDLE: busy=0, sclk=0, le=0; on rising edge -> START_WAIT, busy=1 on the next cycle, word index cleared to 0.
REQ-019 START_WAIT: counts exactly START_DLY cycles, then -> FETCH.
REQ-020 FETCH (1 cycle): rdaddr <= word index; -> WAIT (1 cycle) -> LOAD (1 cycle): 16-bit shift register <= rddata; -> SHIFT.
REQ-021 SHIFT: per bit, sdo = shift register bit 15 and sclk low for CLK_DIV cycles, then sclk high for CLK_DIV cycles; shift left by one on the sclk falling transition; sdo changes only while sclk is low.
REQ-022 After the 16th sclk high phase of a word: sclk=0; if word index < N_LED-1, increment the index and -> FETCH; otherwise -> LATCH.
REQ-023 Per-word time is exactly 3 + 32*CLK_DIV clk cycles (67 at default).
REQ-024 LATCH: le=1, sclk=0, sdo=0 for exactly LAT_W cycles -> DONE.
REQ-025 DONE (1 cycle): frame_done=1; busy=0 on the following cycle; -> IDLE.
REQ-026 A rising edge in any state other than IDLE is ignored for sequencing and pulses frame_overrun for 1 cycle.
REQ-027 A rising edge coincident with DONE counts as an overrun; a rising edge in the cycle after DONE (IDLE) starts a new frame.
REQ-028 The word index is 10 bits; rdaddr never exceeds N_LED-1 and never wraps within a frame.
REQ-029 Exactly 16*N_LED sclk rising edges and one le pulse per completed frame.

Reset
REQ-030 While rst_n=0: state IDLE, rdaddr=0, sdo=0, sclk=0, le=0, busy=0, frame_done=0, frame_overrun=0, shift register 0, all counters 0, edge-detect copy=1.
REQ-031 Reset asserted mid-frame aborts the frame immediately; no le pulse and no frame_done pulse are issued for the partial frame.
REQ-032 After release, a new frame starts only on a fresh low-to-high sdbpflag transition.

Verification
REQ-033 RAM model holds addr k = 16'hA000+k; pulse sdbpflag -> 360 words captured MSB first on sclk rise, word k = 16'hA000+k, rdaddr sequence 0..359, one le pulse 4 cycles wide, frame_done once.
REQ-034 Timing, defaults: frame_done rises exactly 400 + 360*67 + 4 = 24524 cycles after the cycle in which busy first reads 1 (±1 documented in the bench); sclk period 4 cycles, 5760 rising edges.
REQ-035 Second sdbpflag rising edge 1000 cycles into a frame -> frame_overrun 1-cycle pulse, frame proceeds unchanged, no second frame starts.
REQ-036 rst_n low at word 100, bit 7 -> all outputs 0 within the reset, no le or frame_done; next sdbpflag edge produces a full correct frame.
REQ-037 sdbpflag high across reset release -> no frame; drop it low then high -> frame starts.
REQ-038 N_LED=3, CLK_DIV=1, LAT_W=1 with data 16'hFFFF, 16'h0000, 16'h8001 -> exactly 48 sclk rises, correct bit stream, le width 1.

Source files
------------

// File: rtl/sdbp_reader.sv
// -----------------------------------------------------------------------------
// sdbp_reader
//
// Streams one frame of 16-bit LED brightness words from a synchronous frame
// RAM to a serial LED driver chain. A rising edge on sdbpflag starts a frame.
// The frame begins with a fixed start delay. Each word is then fetched,
// loaded and shifted out MSB first on sdo/sclk. After the last word, le is
// pulsed and frame_done is raised for one cycle.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   sdbpflag      frame-start flag from the RAM writer (rising edge only)
//   rdaddr[9:0]   frame RAM read address (registered)
//   rddata[15:0]  frame RAM read data, valid one clk after rdaddr changes
//   sdo           serial data, changes only while sclk is low
//   sclk          serial clock, the driver samples sdo on its rising edge
//   le            latch enable, high for LAT_W cycles after the last bit
//   busy          high while a frame is in progress
//   frame_done    one-cycle pulse when a frame completes
//   frame_overrun one-cycle pulse when a start edge arrives while not idle
// -----------------------------------------------------------------------------
module sdbp_reader #(
    parameter int N_LED     = 360,  // words per frame, 1..1024
    parameter int CLK_DIV   = 2,    // clk cycles per sclk half-period, >= 1
    parameter int START_DLY = 400,  // clk cycles from start edge to first fetch
    parameter int LAT_W     = 4     // clk cycles le is held high
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdbpflag,
    output logic [9:0]  rdaddr,
    input  logic [15:0] rddata,
    output logic        sdo,
    output logic        sclk,
    output logic        le,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_WAIT,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    // One shared down-the-line counter serves the start delay, the sclk
    // half-period and the latch width, since those phases never overlap.
    localparam int CNT_MAX = (START_DLY > CLK_DIV)
                           ? ((START_DLY > LAT_W) ? START_DLY : LAT_W)
                           : ((CLK_DIV   > LAT_W) ? CLK_DIV   : LAT_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_DLY - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(LAT_W - 1);
    localparam logic [9:0]       LAST_WORD  = 10'(N_LED - 1);

    state_t           state;
    logic             flag_q;
    logic [9:0]       word_idx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [15:0]      shreg;
    logic             start_edge;

    // The copy resets to 1 so that a flag already high when reset is
    // released is not mistaken for a new frame request.
    assign start_edge = sdbpflag & ~flag_q;

    // NOTE: every register here is updated with <= so all branches see the
    // values from before the clock edge; mixing in = would make the result
    // depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            flag_q        <= 1'b1;
            word_idx      <= '0;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            rdaddr        <= '0;
            sdo           <= 1'b0;
            sclk          <= 1'b0;
            le            <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            flag_q <= sdbpflag;

            // NOTE: the two pulse outputs default low every cycle and are
            // only raised by the branch that wants them, which keeps them
            // exactly one cycle wide.
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;

            if (start_edge && (state != S_IDLE)) begin
                frame_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    sclk <= 1'b0;
                    le   <= 1'b0;
                    if (start_edge) begin
                        busy     <= 1'b1;
                        word_idx <= '0;
                        cnt      <= '0;
                        state    <= S_START_WAIT;
                    end
                end

                S_START_WAIT: begin
                    if (cnt == START_LAST) begin
                        cnt   <= '0;
                        state <= S_FETCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_FETCH: begin
                    rdaddr <= word_idx;
                    state  <= S_WAIT;
                end

                // The RAM registers the address during this cycle.
                S_WAIT: begin
                    state <= S_LOAD;
                end

                S_LOAD: begin
                    shreg   <= rddata;
                    sdo     <= rddata[15];
                    sclk    <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    state   <= S_SHIFT;
                end

                // sclk itself records which half of the bit period we are in.
                S_SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                if (word_idx < LAST_WORD) begin
                                    word_idx <= word_idx + 10'd1;
                                    state    <= S_FETCH;
                                end else begin
                                    le    <= 1'b1;
                                    sdo   <= 1'b0;
                                    state <= S_LATCH;
                                end
                            end else begin
                                // Advance on the falling transition so sdo is
                                // stable for the whole high phase.
                                shreg   <= {shreg[14:0], 1'b0};
                                sdo     <= shreg[14];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                end

                S_LATCH: begin
                    if (cnt == LAT_LAST) begin
                        cnt        <= '0;
                        le         <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdbp_reader.sv
// -----------------------------------------------------------------------------
// tb_sdbp_reader
//
// Two instances: dut0 with default parameters and dut1 with N_LED=3,
// CLK_DIV=1, LAT_W=1, START_DLY=5. Each has its own synchronous RAM model.
// Starting a frame pushes the words the driver chain should receive into a
// scoreboard queue. A monitor reassembles words from sdo on every sclk rise,
// then pops and compares them. It also counts sclk rises, le pulses and
// done/overrun pulses, and watches sclk period, sdo stability and the
// rdaddr range. Frame length is checked against the closed-form
// START_DLY + N_LED*(3+32*CLK_DIV) + LAT_W, counted from the cycle in which
// busy first reads 1 to the cycle in which frame_done reads 1. The expected
// offset between these two cycles is exact (no +-1 slack).
// -----------------------------------------------------------------------------
module tb_sdbp_reader;

    logic        clk;
    logic        rst_n;
    logic        sdbpflag      [2];
    logic [9:0]  rdaddr        [2];
    logic [15:0] rddata        [2];
    logic        sdo           [2];
    logic        sclk          [2];
    logic        le            [2];
    logic        busy          [2];
    logic        frame_done    [2];
    logic        frame_overrun [2];

    logic [15:0] mem0 [0:359];
    logic [15:0] mem1 [0:2];

    sdbp_reader dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .sdbpflag      (sdbpflag[0]),
        .rdaddr        (rdaddr[0]),
        .rddata        (rddata[0]),
        .sdo           (sdo[0]),
        .sclk          (sclk[0]),
        .le            (le[0]),
        .busy          (busy[0]),
        .frame_done    (frame_done[0]),
        .frame_overrun (frame_overrun[0])
    );

    sdbp_reader #(.N_LED(3), .CLK_DIV(1), .START_DLY(5), .LAT_W(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .sdbpflag      (sdbpflag[1]),
        .rdaddr        (rdaddr[1]),
        .rddata        (rddata[1]),
        .sdo           (sdo[1]),
        .sclk          (sclk[1]),
        .le            (le[1]),
        .busy          (busy[1]),
        .frame_done    (frame_done[1]),
        .frame_overrun (frame_overrun[1])
    );

    // Synchronous-read frame RAMs
    always @(posedge clk) begin
        rddata[0] <= (rdaddr[0] < 10'd360) ? mem0[rdaddr[0]] : 16'hDEAD;
        rddata[1] <= (rdaddr[1] < 10'd3)   ? mem1[rdaddr[1]] : 16'hDEAD;
    end

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Per-instance parameters
    function automatic int n_of(input int d);  return (d == 0) ? 360 : 3; endfunction
    function automatic int cd_of(input int d); return (d == 0) ? 2   : 1; endfunction
    function automatic int sd_of(input int d); return (d == 0) ? 400 : 5; endfunction
    function automatic int lw_of(input int d); return (d == 0) ? 4   : 1; endfunction

    function automatic int frame_cycles(input int d);
        return sd_of(d) + n_of(d) * (3 + 32 * cd_of(d)) + lw_of(d);
    endfunction

    // Scoreboard
    typedef struct {
        int          d;
        int          k;
        logic [15:0] w;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_word(input int d, input logic [15:0] got);
        exp_t e;
        check($sformatf("word_expected dut%0d", d), 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("word_owner dut%0d", d), 32'(d), 32'(e.d));
            check($sformatf("word[%0d] dut%0d", e.k, d), 32'(got), 32'(e.w));
        end
    endtask

    // Monitor state
    int          cyc;
    int          bitcnt     [2];
    int          words_done [2];
    int          rises      [2];
    int          last_rise  [2];
    int          le_count   [2];
    int          done_count [2];
    int          ovr_count  [2];
    int          period_err [2];
    int          glitch_err [2];
    int          addr_err   [2];
    int          le_run     [2];
    int          dn_run     [2];
    int          ov_run     [2];
    logic [15:0] shw        [2];
    logic        sclk_p     [2];
    logic        sdo_p      [2];
    logic        le_p       [2];
    logic        dn_p       [2];
    logic        ov_p       [2];

    initial begin
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            bitcnt[d] = 0; words_done[d] = 0; rises[d] = 0; last_rise[d] = 0;
            le_count[d] = 0; done_count[d] = 0; ovr_count[d] = 0;
            period_err[d] = 0; glitch_err[d] = 0; addr_err[d] = 0;
            le_run[d] = 0; dn_run[d] = 0; ov_run[d] = 0; shw[d] = '0;
            sclk_p[d] = 1'b0; sdo_p[d] = 1'b0; le_p[d] = 1'b0;
            dn_p[d] = 1'b0; ov_p[d] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    bitcnt[d] = 0;
                    le_run[d] = 0;
                    dn_run[d] = 0;
                    ov_run[d] = 0;
                end else begin
                    if (sclk[d] && !sclk_p[d]) begin
                        if (bitcnt[d] != 0 && (cyc - last_rise[d]) != 2 * cd_of(d))
                            period_err[d]++;
                        last_rise[d] = cyc;
                        rises[d]++;
                        shw[d] = {shw[d][14:0], sdo[d]};
                        bitcnt[d]++;
                        if (bitcnt[d] == 16) begin
                            bitcnt[d] = 0;
                            words_done[d]++;
                            compare_word(d, shw[d]);
                        end
                    end
                    if (sclk[d] && (sdo[d] !== sdo_p[d])) glitch_err[d]++;
                    if (int'(rdaddr[d]) > n_of(d) - 1) addr_err[d]++;

                    if (le[d]) le_run[d]++;
                    if (le[d] && !le_p[d]) le_count[d]++;
                    if (!le[d] && le_p[d]) begin
                        check($sformatf("le_width dut%0d", d), 32'(le_run[d]), 32'(lw_of(d)));
                        le_run[d] = 0;
                    end

                    if (frame_done[d]) dn_run[d]++;
                    if (frame_done[d] && !dn_p[d]) done_count[d]++;
                    if (!frame_done[d] && dn_p[d]) begin
                        check($sformatf("frame_done_width dut%0d", d), 32'(dn_run[d]), 32'd1);
                        dn_run[d] = 0;
                    end

                    if (frame_overrun[d]) ov_run[d]++;
                    if (frame_overrun[d] && !ov_p[d]) ovr_count[d]++;
                    if (!frame_overrun[d] && ov_p[d]) begin
                        check($sformatf("overrun_width dut%0d", d), 32'(ov_run[d]), 32'd1);
                        ov_run[d] = 0;
                    end
                end
                sclk_p[d] = sclk[d];
                sdo_p[d]  = sdo[d];
                le_p[d]   = le[d];
                dn_p[d]   = frame_done[d];
                ov_p[d]   = frame_overrun[d];
            end
        end
    end

    // Driver helpers: inputs change 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int frame_t0 [2];

    task automatic check_quiet(input int d, input string tag);
        check($sformatf("%s rdaddr dut%0d", tag, d),        32'(rdaddr[d]),        32'd0);
        check($sformatf("%s sdo dut%0d", tag, d),           32'(sdo[d]),           32'd0);
        check($sformatf("%s sclk dut%0d", tag, d),          32'(sclk[d]),          32'd0);
        check($sformatf("%s le dut%0d", tag, d),            32'(le[d]),            32'd0);
        check($sformatf("%s busy dut%0d", tag, d),          32'(busy[d]),          32'd0);
        check($sformatf("%s frame_done dut%0d", tag, d),    32'(frame_done[d]),    32'd0);
        check($sformatf("%s frame_overrun dut%0d", tag, d), 32'(frame_overrun[d]), 32'd0);
    endtask

    task automatic start_frame(input int d);
        exp_t e;
        int   waited;
        for (int k = 0; k < n_of(d); k++) begin
            e.d = d;
            e.k = k;
            e.w = (d == 0) ? mem0[k] : mem1[k];
            exp_q.push_back(e);
        end
        words_done[d] = 0;
        sdbpflag[d] = 1'b1;
        waited = 0;
        while (!busy[d] && waited < 10) begin
            tick();
            waited++;
        end
        check($sformatf("start_latency dut%0d", d), 32'(waited), 32'd1);
        sdbpflag[d] = 1'b0;
        frame_t0[d] = cyc;
    endtask

    // post: 0 = nothing after done, 1 = start edge coincident with DONE,
    //       2 = leave the bench in the IDLE cycle right after DONE.
    task automatic finish_frame(input int d, input int ovr_at, input int post);
        int r0, l0, dn0, ov0, pe0, ge0, ae0, budget;
        r0 = rises[d]; l0 = le_count[d]; dn0 = done_count[d]; ov0 = ovr_count[d];
        pe0 = period_err[d]; ge0 = glitch_err[d]; ae0 = addr_err[d];
        budget = frame_cycles(d) + 100;
        while (!frame_done[d] && (cyc - frame_t0[d]) < budget) begin
            if (ovr_at > 0 && (cyc - frame_t0[d]) == ovr_at)     sdbpflag[d] = 1'b1;
            if (ovr_at > 0 && (cyc - frame_t0[d]) == ovr_at + 3) sdbpflag[d] = 1'b0;
            tick();
        end
        check($sformatf("frame_time dut%0d", d), 32'(cyc - frame_t0[d]), 32'(frame_cycles(d)));
        check($sformatf("sclk_rises dut%0d", d), 32'(rises[d] - r0), 32'(16 * n_of(d)));
        check($sformatf("le_pulses dut%0d", d), 32'(le_count[d] - l0), 32'd1);
        check($sformatf("done_pulses dut%0d", d), 32'(done_count[d] - dn0), 32'd1);
        check($sformatf("overruns dut%0d", d), 32'(ovr_count[d] - ov0), (ovr_at > 0) ? 32'd1 : 32'd0);
        check($sformatf("words_left dut%0d", d), 32'(exp_q.size()), 32'd0);
        check($sformatf("rdaddr_last dut%0d", d), 32'(rdaddr[d]), 32'(n_of(d) - 1));
        check($sformatf("sclk_period_errs dut%0d", d), 32'(period_err[d] - pe0), 32'd0);
        check($sformatf("sdo_high_changes dut%0d", d), 32'(glitch_err[d] - ge0), 32'd0);
        check($sformatf("rdaddr_range_errs dut%0d", d), 32'(addr_err[d] - ae0), 32'd0);

        if (post == 1) begin
            sdbpflag[d] = 1'b1;
            tick();
            check($sformatf("overrun_at_done dut%0d", d), 32'(frame_overrun[d]), 32'd1);
            sdbpflag[d] = 1'b0;
            repeat (3) tick();
            check($sformatf("no_start_from_done dut%0d", d), 32'(busy[d]), 32'd0);
        end else begin
            tick();
            check($sformatf("busy_after_done dut%0d", d), 32'(busy[d]), 32'd0);
            if (post == 0) begin
                repeat (5) tick();
                check($sformatf("no_second_frame dut%0d", d), 32'(busy[d]), 32'd0);
            end
        end
    endtask

    // Stimulus
    initial begin
        int reached, l0, dn0;
        rst_n       = 1'b0;
        sdbpflag[0] = 1'b0;
        sdbpflag[1] = 1'b0;
        for (int k = 0; k < 360; k++) mem0[k] = 16'hA000 + 16'(k);
        for (int k = 0; k < 3; k++)   mem1[k] = '0;
        repeat (3) tick();
        check_quiet(0, "reset");
        check_quiet(1, "reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Reference frame with an overrun edge 1000 cycles in
        start_frame(0);
        finish_frame(0, 1000, 0);

        // Reset at word 100, bit 7, with the flag held high across release
        for (int k = 0; k < 360; k++) mem0[k] = 16'($urandom);
        start_frame(0);
        reached = 0;
        for (int i = 0; i < 100 * 67 + 1000 && reached == 0; i++) begin
            if (words_done[0] == 100 && bitcnt[0] == 7) reached = 1;
            else tick();
        end
        check("abort_point_reached", 32'(reached), 32'd1);
        l0 = le_count[0];
        dn0 = done_count[0];
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_quiet(0, "abort_reset");
        sdbpflag[0] = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("flag_high_at_release_busy", 32'(busy[0]), 32'd0);
        check("abort_le_pulses", 32'(le_count[0] - l0), 32'd0);
        check("abort_done_pulses", 32'(done_count[0] - dn0), 32'd0);
        sdbpflag[0] = 1'b0;
        tick();
        for (int k = 0; k < 360; k++) mem0[k] = 16'($urandom);
        start_frame(0);
        finish_frame(0, 0, 0);

        // Small instance: fixed pattern, then restart in the IDLE after DONE
        mem1[0] = 16'hFFFF;
        mem1[1] = 16'h0000;
        mem1[2] = 16'h8001;
        start_frame(1);
        finish_frame(1, 0, 2);
        for (int k = 0; k < 3; k++) mem1[k] = 16'($urandom);
        start_frame(1);
        finish_frame(1, 20, 1);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) mem1[k] = 16'($urandom);
            start_frame(1);
            finish_frame(1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #(40 * 150000);
        $display("FAIL watchdog: simulation exceeded 150000 cycles");
        $fatal(1);
    end

endmodule
